mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler.sv | 154 +++++++++++++++
 tb/tb_mole_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round scheduler: gap/show timing, mole pick, hit/miss scoring
//
// Ports:
//   game_clk   in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   tick       in   timebase enable; gap/window timers advance only when high
//   start      in   begin a game (honoured only in IDLE and DONE)
//   rnd[7:0]   in   free-running random value; rnd[2:0] picks the mole
//   toggle[7:0] in  one-cycle pulse per switch flip, bit n = switch n
//   mole[7:0]  out  one-hot LED of the visible mole, 0 when none
//   hit        out  one-cycle pulse when the visible mole is whacked
//   miss       out  one-cycle pulse when the mole is lost (timeout or wrong switch)
//   round[7:0] out  moles resolved in the current game
//   busy       out  high while in GAP or SHOW
//   game_over  out  high while in DONE
module mole_scheduler #(
  parameter logic [7:0] WIN_INIT  = 8'd200,
  parameter logic [7:0] WIN_MIN   = 8'd40,
  parameter logic [7:0] WIN_STEP  = 8'd8,
  parameter logic [7:0] GAP_TICKS = 8'd25,
  parameter logic [7:0] ROUNDS    = 8'd60
) (
  input  logic       game_clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] rnd,
  input  logic [7:0] toggle,
  output logic [7:0] mole,
  output logic       hit,
  output logic       miss,
  output logic [7:0] round,
  output logic       busy,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] mole_n, round_n;
  logic [7:0] window, window_n;
  logic [7:0] gap_cnt, gap_cnt_n;
  logic [7:0] win_cnt, win_cnt_n;
  logic [2:0] prev_idx, prev_idx_n, idx;
  logic [7:0] win_dec;
  logic       hit_n, miss_n, resolve, last_round;

  // Never show the same mole twice in a row: bump a repeated index by one.
  assign idx = (rnd[2:0] == prev_idx) ? rnd[2:0] + 3'd1 : rnd[2:0];

  // Shrink the window after a hit, clamped at WIN_MIN without 8-bit underflow.
  assign win_dec = ((window < WIN_STEP) || ((window - WIN_STEP) < WIN_MIN))
                   ? WIN_MIN : window - WIN_STEP;

  // ROUNDS of 0 behaves like 1, so compare with >= in 9 bits.
  assign last_round = ({1'b0, round} + 9'd1) >= {1'b0, ROUNDS};

  always_comb begin
    state_n    = state;
    mole_n     = mole;
    round_n    = round;
    window_n   = window;
    gap_cnt_n  = gap_cnt;
    win_cnt_n  = win_cnt;
    prev_idx_n = prev_idx;
    hit_n      = 1'b0;
    miss_n     = 1'b0;
    resolve    = 1'b0;

    case (state)
      IDLE, DONE: begin
        mole_n = 8'd0;
        if (start) begin
          round_n   = 8'd0;
          window_n  = WIN_INIT;
          gap_cnt_n = GAP_TICKS;
          state_n   = GAP;
        end
      end

      GAP: begin
        mole_n = 8'd0;
        if (tick) begin
          // A count of 0 is treated as 1 so a zero parameter still means one tick.
          if (gap_cnt <= 8'd1) begin
            state_n    = SHOW;
            mole_n     = 8'd1 << idx;
            prev_idx_n = idx;
            win_cnt_n  = window;
            gap_cnt_n  = 8'd0;
          end else begin
            gap_cnt_n = gap_cnt - 8'd1;
          end
        end
      end

      SHOW: begin
        // Priority: hit, then wrong switch, then timeout.
        if ((toggle & mole) != 8'd0) begin
          hit_n    = 1'b1;
          window_n = win_dec;
          resolve  = 1'b1;
        end else if ((toggle & ~mole) != 8'd0) begin
          miss_n  = 1'b1;
          resolve = 1'b1;
        end else if (tick && (win_cnt <= 8'd1)) begin
          miss_n  = 1'b1;
          resolve = 1'b1;
        end else if (tick) begin
          win_cnt_n = win_cnt - 8'd1;
        end

        if (resolve) begin
          mole_n    = 8'd0;
          round_n   = round + 8'd1;
          win_cnt_n = 8'd0;
          gap_cnt_n = GAP_TICKS;
          state_n   = last_round ? DONE : GAP;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (rst) begin
      state     <= IDLE;
      mole      <= 8'd0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      round     <= 8'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      window    <= WIN_INIT;
      gap_cnt   <= 8'd0;
      win_cnt   <= 8'd0;
      prev_idx  <= 3'd0;
    end else begin
      state     <= state_n;
      mole      <= mole_n;
      hit       <= hit_n;
      miss      <= miss_n;
      round     <= round_n;
      busy      <= (state_n == GAP) || (state_n == SHOW);
      game_over <= (state_n == DONE);
      window    <= window_n;
      gap_cnt   <= gap_cnt_n;
      win_cnt   <= win_cnt_n;
      prev_idx  <= prev_idx_n;
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - directed self-checking bench for mole_scheduler
`timescale 1ns/1ps
module tb_mole_scheduler;

  logic       game_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rnd = 8'd0;
  logic [7:0] toggle = 8'd0;
  logic [7:0] mole;
  logic       hit, miss;
  logic [7:0] round;
  logic       busy, game_over;

  int checks = 0;
  int errors = 0;

  mole_scheduler #(
    .WIN_INIT (8'd4),
    .WIN_MIN  (8'd40),
    .WIN_STEP (8'd8),
    .GAP_TICKS(8'd2),
    .ROUNDS   (8'd2)
  ) dut (
    .game_clk (game_clk),
    .rst      (rst),
    .tick     (tick),
    .start    (start),
    .rnd      (rnd),
    .toggle   (toggle),
    .mole     (mole),
    .hit      (hit),
    .miss     (miss),
    .round    (round),
    .busy     (busy),
    .game_over(game_over)
  );

  always #5 game_clk = ~game_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge game_clk);
    #1;
  endtask

  // Advance until a mole lights; a blown budget is a failure.
  task automatic wait_mole(input string tag);
    int n = 0;
    while (mole == 8'd0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, {31'd0, mole != 8'd0}, 32'd1);
  endtask

  // Count edges from mole-set until the miss pulse.
  task automatic count_timeout(input string tag, input int exp_ticks);
    int n = 0;
    while (!miss && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, exp_ticks);
  endtask

  initial begin
    step();
    step();
    chk("rst_mole", mole, 0);
    chk("rst_round", round, 0);
    chk("rst_flags", {hit, miss, busy, game_over}, 0);
    rst = 1'b0;

    // Game 1: start latency, timeout, repeat-index bump, clamp on hit, DONE.
    rnd = 8'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("g1_busy", busy, 1);
    chk("g1_gap_mole", mole, 0);
    step();
    chk("g1_gap_mole2", mole, 0);
    step();
    chk("g1_first_mole", mole, 8'h08);
    count_timeout("g1_timeout_ticks", 4);
    chk("g1_to_hit", hit, 0);
    chk("g1_to_round", round, 1);
    chk("g1_to_mole", mole, 0);
    step();
    chk("g1_miss_pulse", miss, 0);
    step();
    chk("g1_second_mole", mole, 8'h10);
    toggle = 8'h10;
    step();
    toggle = 8'h00;
    chk("g1_hit", hit, 1);
    chk("g1_hit_nomiss", miss, 0);
    chk("g1_hit_mole", mole, 0);
    chk("g1_hit_round", round, 2);
    chk("g1_done", {busy, game_over}, 2'b01);
    step();
    chk("g1_hit_pulse", hit, 0);
    chk("g1_done_hold", {round, game_over}, {8'd2, 1'b1});

    // Game 2: restart, hit beats wrong switch, clamped 40-tick window.
    rnd = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("g2_restart", {round, busy, game_over}, {8'd0, 1'b1, 1'b0});
    wait_mole("g2_m1");
    chk("g2_m1_val", mole, 8'h01);
    toggle = 8'h03;
    step();
    toggle = 8'h00;
    chk("g2_hit_prio", {hit, miss}, 2'b10);
    chk("g2_round", round, 1);
    wait_mole("g2_m2");
    chk("g2_m2_val", mole, 8'h02);
    count_timeout("g2_clamp_ticks", 40);
    chk("g2_done", {round, mole, busy, game_over}, {8'd2, 8'd0, 1'b0, 1'b1});

    // Game 3: wrong switch, start/toggle ignored in GAP, tick gating, reset in SHOW.
    rnd = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_mole("g3_m1");
    chk("g3_m1_val", mole, 8'h04);
    toggle = 8'h02;
    step();
    toggle = 8'h00;
    chk("g3_wrong", {hit, miss}, 2'b01);
    chk("g3_round", round, 1);
    start = 1'b1;
    toggle = 8'hff;
    step();
    start = 1'b0;
    toggle = 8'h00;
    chk("g3_gap_ignore", {round, hit, miss, mole}, {8'd1, 1'b0, 1'b0, 8'd0});
    rnd = 8'd7;
    step();
    chk("g3_m2_val", mole, 8'h80);
    tick = 1'b0;
    repeat (10) step();
    chk("g3_tick_hold", {mole, miss}, {8'h80, 1'b0});
    tick = 1'b1;
    rst = 1'b1;
    start = 1'b1;
    toggle = 8'h80;
    step();
    rst = 1'b0;
    start = 1'b0;
    toggle = 8'h00;
    chk("g3_rst_all", {mole, hit, miss, round, busy, game_over}, 0);
    toggle = 8'h80;
    step();
    toggle = 8'h00;
    chk("g3_post_rst", {mole, hit, miss, busy, game_over}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
